// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB4 slave register file for the SPI subsystem. Provides a
//               bank of byte-strobed read/write control registers and
//               read-only status registers, with programmable wait states,
//               error response and per-register write pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
  parameter int                             ADDR_WIDTH  = 5,
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             NUM_REGS    = 8,
  parameter int                             WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int c_NUM_BYTES = DATA_WIDTH / 8;
  localparam int c_OFS       = $clog2(c_NUM_BYTES);
  localparam int c_IDX_W     = ADDR_WIDTH - c_OFS;

  localparam logic [c_IDX_W:0] c_NUM_REGS_EXT = (c_IDX_W + 1)'(NUM_REGS);
  localparam logic [3:0]       c_WAIT_INIT    = 4'(WAIT_STATES);

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_ACCESS = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;

  // Transfer attributes are captured in the setup cycle; APB holds them
  // stable for the whole transfer, so decode runs from flops only.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;

  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_oob;
  logic                  w_misalign;
  logic                  w_sel_ro;
  logic                  w_err;
  logic                  w_ready;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic [DATA_WIDTH-1:0] w_rd_word [NUM_REGS];
  logic [NUM_REGS-1:0]   w_pulse_nxt;
  logic [NUM_REGS-1:0]   r_wr_pulse;

  // --------------------------------------------------------------------------
  // FSM: state register and wait counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM: next-state and wait-counter decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (PSEL) begin
          w_state_nxt = c_ST_ACCESS;
          w_cnt_nxt   = c_WAIT_INIT;
        end
      end
      c_ST_ACCESS: begin
        if (!PSEL || !PENABLE) begin
          // Master abandoned the transfer: nothing is committed.
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM: outputs decoded from registered state
  always_comb begin
    w_ready  = (r_state == c_ST_ACCESS) && (r_cnt == 4'd0);
    w_commit = w_ready && PSEL && PENABLE && r_write && !w_err;
  end

  // --------------------------------------------------------------------------
  // Capture address and direction during the setup cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
    end else if ((r_state == c_ST_IDLE) && PSEL) begin
      r_addr  <= PADDR;
      r_write <= PWRITE;
    end
  end

  assign w_idx = r_addr[ADDR_WIDTH-1:c_OFS];
  assign w_oob = ({1'b0, w_idx} >= c_NUM_REGS_EXT);

  // Byte-lane offset bits only exist for buses wider than one byte.
  if (c_OFS > 0) begin : g_misalign
    assign w_misalign = |r_addr[c_OFS-1:0];
  end else begin : g_no_misalign
    assign w_misalign = 1'b0;
  end

  // Select the addressed register's read word and read-only attribute
  always_comb begin
    w_rd_mux = '0;
    w_sel_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == c_IDX_W'(i)) begin
        w_rd_mux = w_rd_word[i];
        w_sel_ro = RO_MASK[i];
      end
    end
  end

  assign w_err = w_oob | w_misalign | (r_write & w_sel_ro);

  // --------------------------------------------------------------------------
  // Register bank: RO entries pass status through, RW entries hold flops
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign w_rd_word[i]                       = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH]  = RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_data;
      logic [DATA_WIDTH-1:0] w_unused_hw;

      // Status input is meaningless for a read/write register.
      assign w_unused_hw = hw_status[i*DATA_WIDTH +: DATA_WIDTH];

      // Byte-strobed update on a successful completing write to this index
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          r_data <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_commit && (w_idx == c_IDX_W'(i))) begin
          for (int b = 0; b < c_NUM_BYTES; b++) begin
            if (PSTRB[b]) begin
              r_data[b*8 +: 8] <= PWDATA[b*8 +: 8];
            end
          end
        end
      end

      assign w_rd_word[i]                      = r_data;
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_data;
    end
  end

  // --------------------------------------------------------------------------
  // Write pulse decode, one-hot on the committed index
  always_comb begin
    w_pulse_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pulse_nxt[i] = w_commit && (w_idx == c_IDX_W'(i));
    end
  end

  // Register the write pulse so it lines up with the updated reg_q
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_pulse_nxt;
    end
  end

  assign wr_pulse = r_wr_pulse;

  // --------------------------------------------------------------------------
  // Bus response: read data only on a valid completing read
  always_comb begin
    PREADY  = w_ready;
    PSLVERR = w_ready & w_err;
    PRDATA  = (w_ready && !w_err && !r_write) ? w_rd_mux : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regfile
// Description : Directed self-checking bench for apb_slave_regfile. Two
//               instances share the bus: one with no wait states and one
//               with three, selected by separate PSEL lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

  localparam int c_AW = 6;
  localparam int c_DW = 32;
  localparam int c_NR = 8;
  localparam logic [c_NR-1:0] c_RO = 8'h08;
  localparam logic [c_NR*c_DW-1:0] c_RV = {
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_00A5, 32'h1234_5678};
  localparam logic [c_NR*c_DW-1:0] c_HW = {
    32'hBAD0_0007, 32'hBAD0_0006, 32'hBAD0_0005, 32'hBAD0_0004,
    32'hDEAD_BEEF, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};

  logic              clk;
  logic              rst_n;
  logic              r_sel0;
  logic              r_sel3;
  logic              r_enable;
  logic              r_write;
  logic [c_AW-1:0]   r_addr;
  logic [c_DW-1:0]   r_wdata;
  logic [3:0]        r_strb;
  logic [c_NR*c_DW-1:0] r_hw;

  logic [c_DW-1:0]      w_rdata0, w_rdata3;
  logic                 w_ready0, w_ready3;
  logic                 w_err0, w_err3;
  logic [c_NR*c_DW-1:0] w_q0, w_q3;
  logic [c_NR-1:0]      w_pulse0, w_pulse3;

  int n_total;
  int n_bad;
  int cyc;

  apb_slave_regfile #(
    .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .NUM_REGS(c_NR), .WAIT_STATES(0),
    .RO_MASK(c_RO), .RESET_VAL(c_RV)
  ) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(r_sel0), .PENABLE(r_enable),
    .PWRITE(r_write), .PADDR(r_addr), .PWDATA(r_wdata), .PSTRB(r_strb),
    .PRDATA(w_rdata0), .PREADY(w_ready0), .PSLVERR(w_err0),
    .reg_q(w_q0), .hw_status(r_hw), .wr_pulse(w_pulse0)
  );

  apb_slave_regfile #(
    .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .NUM_REGS(c_NR), .WAIT_STATES(3),
    .RO_MASK(c_RO), .RESET_VAL(c_RV)
  ) u_dut3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(r_sel3), .PENABLE(r_enable),
    .PWRITE(r_write), .PADDR(r_addr), .PWDATA(r_wdata), .PSTRB(r_strb),
    .PRDATA(w_rdata3), .PREADY(w_ready3), .PSLVERR(w_err3),
    .reg_q(w_q3), .hw_status(r_hw), .wr_pulse(w_pulse3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the completing edge
  // with the bus idle, so a following call is a back-to-back transfer.
  task automatic apb_xfer(input bit use3, input bit wr, input logic [c_AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er, output int ncyc);
    int n;
    r_sel0 = !use3; r_sel3 = use3; r_enable = 1'b0;
    r_write = wr; r_addr = a; r_wdata = d; r_strb = s;
    n = 1;
    #1;
    chk("setup_ready_low", use3 ? w_ready3 : w_ready0, 1'b0);
    @(posedge clk); #1;
    r_enable = 1'b1;
    n = 2;
    while (!(use3 ? w_ready3 : w_ready0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_seen", use3 ? w_ready3 : w_ready0, 1'b1);
    rd   = use3 ? w_rdata3 : w_rdata0;
    er   = use3 ? w_err3 : w_err0;
    ncyc = n;
    @(posedge clk); #1;
    r_sel0 = 1'b0; r_sel3 = 1'b0; r_enable = 1'b0;
  endtask

  initial begin
    logic [31:0]          rd;
    logic                 er;
    int                   n;
    int                   c0;
    logic [c_NR*c_DW-1:0] exp0;

    n_total = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; r_sel0 = 1'b0; r_sel3 = 1'b0; r_enable = 1'b0;
    r_write = 1'b0; r_addr = '0; r_wdata = '0; r_strb = '0; r_hw = c_HW;
    exp0 = c_RV;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_ready", w_ready0, 1'b0);
    chk("rst_slverr", w_err0, 1'b0);
    chk("rst_prdata", w_rdata0, 32'h0);
    chk("rst_pulse", w_pulse0, 8'h00);
    chk("rst_regq", w_q0, c_RV);

    // Default read of reg1
    apb_xfer(0, 0, 6'h04, 32'h0, 4'h0, rd, er, n);
    chk("rd1_data", rd, 32'h0000_00A5);
    chk("rd1_err", er, 1'b0);
    chk("rd1_cycles", n, 2);

    // Strobed write to reg2 over all-ones
    apb_xfer(0, 1, 6'h08, 32'h1122_3344, 4'b0101, rd, er, n);
    exp0[95:64] = 32'hFF22_FF44;
    chk("wr2_err", er, 1'b0);
    chk("wr2_pulse_on", w_pulse0, 8'h04);
    chk("wr2_regq", w_q0, exp0);
    @(posedge clk); #1;
    chk("wr2_pulse_off", w_pulse0, 8'h00);
    apb_xfer(0, 0, 6'h08, 32'h0, 4'h0, rd, er, n);
    chk("rd2_data", rd, 32'hFF22_FF44);

    // PSTRB=0 write: no data change, pulse still fires
    apb_xfer(0, 1, 6'h18, 32'hFFFF_FFFF, 4'b0000, rd, er, n);
    chk("strb0_pulse", w_pulse0, 8'h40);
    chk("strb0_regq", w_q0, exp0);

    // Wait states on the second instance
    apb_xfer(1, 0, 6'h04, 32'h0, 4'h0, rd, er, n);
    chk("ws_cycles", n, 5);
    chk("ws_data", rd, 32'h0000_00A5);

    // Error: out-of-range index
    apb_xfer(0, 1, 6'h20, 32'hAAAA_AAAA, 4'hF, rd, er, n);
    chk("oob_err", er, 1'b1);
    chk("oob_pulse", w_pulse0, 8'h00);
    chk("oob_regq", w_q0, exp0);

    // Error: misaligned write
    apb_xfer(0, 1, 6'h05, 32'hBBBB_BBBB, 4'hF, rd, er, n);
    chk("mis_err", er, 1'b1);
    chk("mis_pulse", w_pulse0, 8'h00);
    chk("mis_regq", w_q0, exp0);

    // Error: misaligned read returns zero data
    apb_xfer(0, 0, 6'h05, 32'h0, 4'h0, rd, er, n);
    chk("misrd_err", er, 1'b1);
    chk("misrd_data", rd, 32'h0);

    // Error: write to read-only reg3
    apb_xfer(0, 1, 6'h0C, 32'hCCCC_CCCC, 4'hF, rd, er, n);
    chk("ro_err", er, 1'b1);
    chk("ro_pulse", w_pulse0, 8'h00);
    chk("ro_regq", w_q0, exp0);

    // Read of read-only reg3 returns status
    apb_xfer(0, 0, 6'h0C, 32'h0, 4'h0, rd, er, n);
    chk("rord_data", rd, 32'hDEAD_BEEF);
    chk("rord_err", er, 1'b0);

    // Abort: PSEL dropped during a wait state of a write to reg0
    r_sel3 = 1'b1; r_enable = 1'b0; r_write = 1'b1; r_addr = 6'h00;
    r_wdata = 32'hCAFE_BABE; r_strb = 4'hF;
    @(posedge clk); #1;
    r_enable = 1'b1;
    @(posedge clk); #1;
    chk("abort_waiting", w_ready3, 1'b0);
    r_sel3 = 1'b0; r_enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_pulse", w_pulse3, 8'h00);
    @(posedge clk); #1;
    chk("abort_regq", w_q3, c_RV);
    apb_xfer(1, 0, 6'h00, 32'h0, 4'h0, rd, er, n);
    chk("abort_next_data", rd, 32'h1234_5678);
    chk("abort_next_cycles", n, 5);

    // Back-to-back write then read of reg4
    c0 = cyc;
    apb_xfer(0, 1, 6'h10, 32'hA1B2_C3D4, 4'hF, rd, er, n);
    apb_xfer(0, 0, 6'h10, 32'h0, 4'h0, rd, er, n);
    exp0[159:128] = 32'hA1B2_C3D4;
    chk("b2b_data", rd, 32'hA1B2_C3D4);
    chk("b2b_cycles", cyc - c0, 4);
    chk("b2b_regq", w_q0, exp0);

    // Reset while a read is completing
    apb_xfer(0, 1, 6'h14, 32'h5555_AAAA, 4'hF, rd, er, n);
    chk("pre_rst_reg5", w_q0[191:160], 32'h5555_AAAA);
    r_sel0 = 1'b1; r_enable = 1'b0; r_write = 1'b0; r_addr = 6'h04;
    @(posedge clk); #1;
    r_enable = 1'b1;
    chk("pre_rst_ready", w_ready0, 1'b1);
    chk("pre_rst_data", w_rdata0, 32'h0000_00A5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", w_ready0, 1'b0);
    chk("mid_rst_slverr", w_err0, 1'b0);
    chk("mid_rst_prdata", w_rdata0, 32'h0);
    chk("mid_rst_pulse", w_pulse0, 8'h00);
    chk("mid_rst_regq", w_q0, c_RV);
    r_sel0 = 1'b0; r_enable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", w_ready0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
